// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, arbiter defaults and arbiter FSM encoding
package uart_pkg;
    localparam int N_REQ_DEF = 4;
    localparam int DATA_BITS_DEF = 8;
    localparam int UART_CLKS_PER_BIT = 868;
    localparam int UART_STOP_BITS = 1;
    typedef enum logic [1:0] {IDLE, SEND, DRAIN, HOLD} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, one-hot winner searching upward from ptr
module rr_pick
    import uart_pkg::*;
#(
    parameter int N = N_REQ_DEF,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win
);
    logic [PW-1:0] idx;
    // walk from lowest to highest priority so the nearest request to ptr overrides
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                win = '0;
                win[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter feeding one uart_tx, with packet locking
// and an idle-timeout that releases a stalled lock.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int HOLD_TIMEOUT = 65535
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_BITS-1:0] req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           grant,
    output logic                       tx_valid,
    output logic [DATA_BITS-1:0]       tx_data,
    input  logic                       tx_ready,
    output logic                       lock_abort
);
    localparam int PW = $clog2(N_REQ);

    arb_state_t state;
    logic [PW-1:0] ptr, own, win_idx, next_ptr;
    logic [N_REQ-1:0] win, sel_oh;
    logic [DATA_BITS-1:0] sel_data;
    logic [15:0] hold_cnt;
    logic release_flag, own_valid, load, timeout;

    rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .req(req_valid),
        .ptr(ptr),
        .win(win)
    );

    // in HOLD the locked owner is the only candidate
    always_comb begin
        sel_oh = state == HOLD ? grant : win;
        win_idx = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) win_idx = PW'(i);
            if (sel_oh[i]) sel_data = req_data[i*DATA_BITS +: DATA_BITS];
        end
    end

    assign own_valid = |(req_valid & grant);
    assign load = tx_ready && (state == IDLE ? |req_valid : state == HOLD && own_valid);
    assign timeout = state == HOLD && !own_valid && hold_cnt == 16'(HOLD_TIMEOUT - 1);
    assign next_ptr = own == PW'(N_REQ - 1) ? '0 : own + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr <= '0;
            own <= '0;
            hold_cnt <= '0;
            release_flag <= 1'b0;
            grant <= '0;
            req_ready <= '0;
            tx_valid <= 1'b0;
            tx_data <= '0;
            lock_abort <= 1'b0;
        end else begin
            req_ready <= '0;
            lock_abort <= 1'b0;
            case (state)
                IDLE, HOLD: begin
                    if (load) begin
                        req_ready <= sel_oh;
                        grant <= sel_oh;
                        if (state == IDLE) own <= win_idx;
                        tx_data <= sel_data;
                        release_flag <= |(req_last & sel_oh);
                        tx_valid <= 1'b1;
                        state <= SEND;
                    end else if (timeout) begin
                        lock_abort <= 1'b1;
                        grant <= '0;
                        ptr <= next_ptr;
                        state <= IDLE;
                    end else if (state == HOLD && !own_valid) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (!tx_ready) begin
                        tx_valid <= 1'b0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (tx_ready && release_flag) begin
                        grant <= '0;
                        ptr <= next_ptr;
                        state <= IDLE;
                    end else if (tx_ready) begin
                        hold_cnt <= '0;
                        state <= HOLD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: table-driven round-robin vectors, directed lock/timeout/stall/reset
// sequences and a randomized run against a transaction-level arbitration model.
module tb_uart_tx_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] req_valid = '0;
    logic [3:0] req_last = '0;
    logic [3:0] req_ready, grant;
    logic [7:0] d [4];
    logic [31:0] req_data;
    logic tx_valid, lock_abort;
    logic tx_ready = 1'b1;
    logic [7:0] tx_data;

    typedef struct {
        logic [3:0] v;
        int w;
    } vec_t;

    int checks = 0, errors = 0, cyc = 0, busy = 0, mptr = 0, mlock = -1;
    bit hold_low = 0, rnd_mode = 0;
    logic [7:0] emitted [$];
    logic [7:0] acc [$];
    int act [4];

    assign req_data = {d[3], d[2], d[1], d[0]};
    always #5 clk = ~clk;

    uart_tx_arb #(.N_REQ(4), .DATA_BITS(8), .HOLD_TIMEOUT(16)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .grant(grant),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .lock_abort(lock_abort)
    );

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // one cycle: observe at negedge, run the uart model, then drive requesters
    task automatic tick();
        int w;
        @(negedge clk);
        cyc++;
        if (rnd_mode) begin
            if (lock_abort) begin
                chk("rnd_abort_locked", 32'(mlock >= 0), 1);
                if (mlock >= 0) mptr = (mlock + 1) % 4;
                mlock = -1;
            end
            if (req_ready != 0) begin
                w = -1;
                if (mlock >= 0) w = mlock;
                else for (int j = 0; j < 4; j++) if (w < 0 && req_valid[(mptr + j) % 4]) w = (mptr + j) % 4;
                chk("rnd_winner", 32'(req_ready), w < 0 ? 32'd0 : 32'd1 << w);
                if (w >= 0) begin
                    chk("rnd_byte", 32'(tx_data), 32'(d[w]));
                    acc.push_back(d[w]);
                    if (req_last[w]) begin
                        mlock = -1;
                        mptr = (w + 1) % 4;
                    end else mlock = w;
                    d[w] = 8'($urandom);
                    req_last[w] = $urandom_range(0, 2) == 0;
                end
            end
        end
        if (busy > 0) busy--;
        if (tx_ready && tx_valid) begin
            if (rnd_mode && acc.size() == 0) chk("rnd_order_unexpected", 32'(tx_data), 32'hffff_ffff);
            else if (rnd_mode) chk("rnd_order", 32'(tx_data), 32'(acc.pop_front()));
            emitted.push_back(tx_data);
            busy = rnd_mode ? int'($urandom_range(1, 6)) : 3;
        end
        tx_ready = busy == 0 && !hold_low;
        if (rnd_mode) begin
            if (cyc % 200 == 0) for (int i = 0; i < 4; i++) act[i] = 50 * int'($urandom_range(0, 2));
            for (int i = 0; i < 4; i++) req_valid[i] = int'($urandom_range(0, 99)) < act[i];
        end
    endtask

    task automatic wait_ready(string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (req_ready == 0 && n < 300);
        if (req_ready == 0) chk({name, "_ready_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(grant == 0 && tx_ready && !tx_valid) && n < 300);
        if (!(grant == 0 && tx_ready && !tx_valid)) chk({name, "_idle_timeout"}, 0, 1);
    endtask

    task automatic wait_rise(string name);
        int n = 0;
        while (!tx_ready && n < 50) begin
            tick();
            n++;
        end
        if (!tx_ready) chk({name, "_rise_timeout"}, 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        hold_low = 0;
        tick();
        tick();
        rst = 1'b0;
        busy = 0;
        tx_ready = 1'b1;
        emitted.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [8];
        int rc [4];
        int abort_at, b2;
        bit early;
        for (int i = 0; i < 4; i++) d[i] = '0;
        tbl[0] = '{v: 4'b0101, w: 0};
        tbl[1] = '{v: 4'b0101, w: 2};
        tbl[2] = '{v: 4'b0011, w: 0};
        tbl[3] = '{v: 4'b1000, w: 3};
        tbl[4] = '{v: 4'b0110, w: 1};
        tbl[5] = '{v: 4'b0011, w: 0};
        tbl[6] = '{v: 4'b1100, w: 2};
        tbl[7] = '{v: 4'b0100, w: 2};

        tick();
        tick();
        chk("reset_tx_valid", 32'(tx_valid), 0);
        chk("reset_tx_data", 32'(tx_data), 0);
        chk("reset_grant", 32'(grant), 0);
        chk("reset_req_ready", 32'(req_ready), 0);
        chk("reset_lock_abort", 32'(lock_abort), 0);
        rst = 1'b0;

        req_last = 4'hF;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) d[i] = 8'(16 * (k + 1) + i);
            req_valid = tbl[k].v;
            wait_ready("rr");
            req_valid = '0;
            chk("rr_grant", 32'(req_ready), 32'd1 << tbl[k].w);
            chk("rr_byte", 32'(tx_data), 32'(16 * (k + 1) + tbl[k].w));
            wait_idle("rr");
        end

        do_reset();
        for (int i = 0; i < 4; i++) begin
            d[i] = 8'(8'h41 + i);
            rc[i] = 0;
        end
        req_last = 4'hF;
        req_valid = 4'hF;
        for (int n = 0; n < 300 && !(emitted.size() == 4 && req_valid == 0 && grant == 0 && tx_ready); n++) begin
            tick();
            for (int i = 0; i < 4; i++) if (req_ready[i]) begin
                rc[i]++;
                req_valid[i] = 1'b0;
            end
        end
        chk("all4_count", 32'(emitted.size()), 4);
        for (int j = 0; j < 4 && j < emitted.size(); j++) chk("all4_order", 32'(emitted[j]), 32'(8'h41 + j));
        for (int i = 0; i < 4; i++) chk("all4_ready_once", 32'(rc[i]), 1);

        do_reset();
        d[2] = 8'h10;
        d[0] = 8'hA0;
        req_last = 4'b0001;
        req_valid = 4'b0100;
        b2 = 0;
        for (int n = 0; n < 300 && !(emitted.size() == 4 && req_valid == 0 && grant == 0 && tx_ready); n++) begin
            tick();
            if (req_ready[2]) begin
                b2++;
                req_valid[0] = 1'b1;
                if (b2 == 3) req_valid[2] = 1'b0;
                else begin
                    d[2] = 8'(8'h10 + b2);
                    req_last[2] = b2 == 2;
                end
            end
            if (req_ready[0]) req_valid[0] = 1'b0;
        end
        chk("pkt_count", 32'(emitted.size()), 4);
        for (int j = 0; j < 3 && j < emitted.size(); j++) chk("pkt_contig", 32'(emitted[j]), 32'(8'h10 + j));
        if (emitted.size() == 4) chk("pkt_then_req0", 32'(emitted[3]), 32'hA0);

        do_reset();
        d[1] = 8'h55;
        d[3] = 8'h77;
        req_last = 4'b1000;
        req_valid = 4'b0010;
        wait_ready("lock");
        chk("lock_first_grant", 32'(req_ready), 32'b0010);
        req_valid = 4'b1000;
        wait_rise("lock");
        abort_at = -1;
        early = 0;
        for (int k = 1; k <= 30 && abort_at < 0; k++) begin
            tick();
            if (req_ready != 0) early = 1;
            if (lock_abort) begin
                abort_at = k;
                chk("abort_grant_cleared", 32'(grant), 0);
            end
        end
        chk("abort_delay", 32'(abort_at), 17);
        chk("hold_ignores_other", 32'(early), 0);
        tick();
        chk("abort_one_cycle", 32'(lock_abort), 0);
        chk("after_abort_winner", 32'(req_ready), 32'b1000);
        req_valid = '0;
        wait_idle("abort");

        do_reset();
        d[1] = 8'h61;
        req_last = '0;
        req_valid = 4'b0010;
        wait_ready("coin");
        req_valid = '0;
        wait_rise("coin");
        early = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (lock_abort || req_ready != 0) early = 1;
        end
        d[1] = 8'h62;
        req_last = 4'b0010;
        req_valid = 4'b0010;
        tick();
        chk("coincide_ready", 32'(req_ready), 32'b0010);
        chk("coincide_no_abort", 32'(lock_abort), 0);
        chk("coincide_byte", 32'(tx_data), 32'h62);
        chk("coincide_quiet_before", 32'(early), 0);
        req_valid = '0;
        wait_idle("coin");

        do_reset();
        hold_low = 1;
        tick();
        d[0] = 8'h36;
        req_last = 4'b0001;
        req_valid = 4'b0001;
        early = 0;
        repeat (100) begin
            tick();
            if (req_ready != 0 || tx_valid) early = 1;
        end
        chk("stall_no_grant", 32'(early), 0);
        hold_low = 0;
        tick();
        chk("stall_release_edge", 32'(tx_valid), 0);
        tick();
        chk("stall_tx_valid", 32'(tx_valid), 1);
        chk("stall_ready", 32'(req_ready), 32'b0001);
        req_valid = '0;
        wait_idle("stall");

        do_reset();
        d[2] = 8'h20;
        req_last = 4'hF;
        req_valid = 4'b0100;
        wait_ready("rst_pre");
        req_valid = '0;
        wait_idle("rst_pre");
        d[0] = 8'h30;
        d[3] = 8'h33;
        req_valid = 4'b1001;
        wait_ready("rst_send");
        chk("pre_reset_winner", 32'(req_ready), 32'b1000);
        rst = 1'b1;
        tick();
        chk("midreset_tx_valid", 32'(tx_valid), 0);
        chk("midreset_grant", 32'(grant), 0);
        chk("midreset_ready", 32'(req_ready), 0);
        rst = 1'b0;
        wait_ready("rst_post");
        chk("post_reset_winner", 32'(req_ready), 32'b0001);
        req_valid = '0;
        wait_idle("rst_post");

        do_reset();
        mptr = 0;
        mlock = -1;
        acc.delete();
        for (int i = 0; i < 4; i++) begin
            act[i] = 50 * int'($urandom_range(1, 2));
            d[i] = 8'($urandom);
            req_last[i] = $urandom_range(0, 2) == 0;
        end
        rnd_mode = 1;
        repeat (3000) tick();
        rnd_mode = 0;
        req_valid = '0;
        wait_idle("rnd");
        chk("rnd_drained", 32'(acc.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters (2..8).
REQ-002 Parameter DATA_BITS, default 8: byte width, equal to the downstream uart_tx DATA_BITS.
REQ-003 Parameter HOLD_TIMEOUT, default 65535: maximum idle cycles a locked packet may hold the grant (1..65535).
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  N_REQ  per-requester byte available.
REQ-007 req_data  input  N_REQ*DATA_BITS  per-requester byte; requester i occupies bits [i*DATA_BITS +: DATA_BITS].
REQ-008 req_last  input  N_REQ  byte is the final byte of the requester's packet.
REQ-009 req_ready  output  N_REQ  one-cycle accept pulse; the byte is consumed on the cycle it is high.
REQ-010 grant  output  N_REQ  one-hot current owner; all zero when unowned.
REQ-011 tx_valid  output  1  drives uart_tx valid.
REQ-012 tx_data  output  DATA_BITS  drives uart_tx data_in; stable while tx_valid is high.
REQ-013 tx_ready  input  1  from uart_tx ready; high means the transmitter is idle.
REQ-014 lock_abort  output  1  one-cycle pulse when a packet lock is released by timeout.

Function
REQ-015 The FSM SHALL have four states: IDLE, SEND, DRAIN and HOLD.
REQ-016 IDLE: when any req_valid is high and tx_ready is high, the block SHALL pick the winner by round-robin, starting at the index after the last winner (index 0 after reset).
REQ-017 On the cycle of a grant, the block SHALL pulse req_ready[winner], register req_data[winner] into tx_data, set grant and tx_valid high, register req_last[winner] as the lock-release flag, and enter SEND.
REQ-018 SEND: tx_valid SHALL stay high and tx_data SHALL stay constant until tx_ready is sampled low; the block SHALL then drop tx_valid the next cycle and enter DRAIN.
REQ-019 DRAIN: the block SHALL wait for tx_ready high; the lock-release flag then decides the next state (REQ-020 when set, REQ-021 when clear).
REQ-020 Flag set: the block SHALL clear grant, set the round-robin pointer to winner+1 (mod N_REQ) and enter IDLE.
REQ-021 Flag clear: the block SHALL enter HOLD with grant unchanged and clear the hold counter.
REQ-022 HOLD: only the granted requester SHALL be served; on its req_valid the block SHALL load it as in REQ-017 (no arbitration, no pointer change) and enter SEND.
REQ-023 HOLD: the hold counter SHALL increment each cycle without req_valid[owner]; at HOLD_TIMEOUT-1 the block SHALL pulse lock_abort, release the grant as in REQ-020 and enter IDLE.
REQ-024 req_valid from non-owners SHALL be ignored outside IDLE; at most one req_ready bit SHALL be high in any cycle.
REQ-025 A requester's req_valid dropping before acceptance SHALL NOT be an error; only req_valid sampled in IDLE or HOLD counts.
REQ-026 Latency from req_valid (with tx_ready high, IDLE) to tx_valid high SHALL be 1 cycle.
REQ-027 If req_valid[owner] and the timeout coincide in HOLD, the byte SHALL win and no lock_abort SHALL be issued.
REQ-028 tx_ready falling while in IDLE or HOLD SHALL have no effect; the block SHALL not grant until tx_ready returns high.

Reset
REQ-029 When rst is high at a clock edge, the block SHALL enter IDLE with tx_valid=0, tx_data=0, grant=0, req_ready=0 and lock_abort=0, the round-robin pointer at 0 and the hold counter at 0.
REQ-030 Reset mid-packet SHALL abandon the byte and the lock with no further req_ready pulse.

Structure
REQ-031 The FSM state encoding and the N_REQ/DATA_BITS defaults SHALL live in a shared package uart_pkg, alongside the uart_tx parameter constants.
REQ-032 The round-robin priority picker SHALL be one sub-module, rr_pick (combinational): inputs are the request vector and the pointer; output is a one-hot winner.

Verification
REQ-033 Bench SHALL cover: all 4 req_valid high with req_last=1 and bytes 0x41..0x44 -> uart_tx emits 0x41,0x42,0x43,0x44 in that order, and each req_ready pulses exactly once.
REQ-034 Bench SHALL cover: requester 2 sends a 3-byte packet 0x10,0x11,0x12 (req_last on 0x12) while requester 0 holds req_valid -> the 0x10..0x12 bytes are contiguous, then 0x?? from requester 0 follows.
REQ-035 Bench SHALL cover: requester 1 sends a locked byte and then stays idle, with HOLD_TIMEOUT=16 -> lock_abort pulses 16 cycles after entering HOLD, grant returns to 0, and requester 3 is served next.
REQ-036 Bench SHALL cover: tx_ready held low for 100 cycles with req_valid[0] high -> no req_ready and no tx_valid until tx_ready rises, then tx_valid is high 1 cycle later.
REQ-037 Bench SHALL cover: rst asserted in SEND -> the next cycle shows tx_valid=0, grant=0 and pointer 0, and requester 0 wins first after reset.
REQ-038 Bench SHALL cover: timeout and req_valid[owner] coincide -> the byte is accepted and lock_abort stays 0.
